// File: rtl/neighbour_scanner_pkg.sv
// Shared types for the Dijkstra relax-phase neighbour scanner.
// Scan FSM encoding and default index/weight widths.
package neighbour_scanner_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int NO_EDGE = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_EMIT,
    S_NEXT,
    S_FIN
  } scan_state_t;

  typedef logic [DEFAULT_INDEX_WIDTH-1:0] index_t;
  typedef logic [DEFAULT_VALUE_WIDTH-1:0] value_t;

endpackage

// File: rtl/neighbour_scanner_if.sv
// EdgeCache query bus plus neighbour output stream.
// master = scanner side, slave = EdgeCache and consumer side.
interface neighbour_scanner_if #(
  parameter int IW = 8,
  parameter int VW = 16
);

  logic          query_enable;
  logic [IW-1:0] from_node;
  logic [IW-1:0] to_node;
  logic          ready;
  logic [VW-1:0] edge_value;

  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_node;
  logic [VW-1:0] out_weight;

  modport master (
    output query_enable,
    output from_node,
    output to_node,
    input  ready,
    input  edge_value,
    output out_valid,
    input  out_ready,
    output out_node,
    output out_weight
  );

  modport slave (
    input  query_enable,
    input  from_node,
    input  to_node,
    output ready,
    output edge_value,
    input  out_valid,
    output out_ready,
    input  out_node,
    input  out_weight
  );

endinterface

// File: rtl/neighbour_scanner.sv
// Walks every column of the source node's adjacency row via EdgeCache
// and streams the nonzero edges out; pulses done after the last column.
module neighbour_scanner
  import neighbour_scanner_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter bit SKIP_SELF   = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] node,
  output logic                   busy,
  output logic                   done,
  neighbour_scanner_if.master    bus
);

  scan_state_t            state_q;
  logic [INDEX_WIDTH-1:0] col_q;
  logic [INDEX_WIDTH-1:0] node_q;
  logic [INDEX_WIDTH-1:0] n_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   qe_q;
  logic                   ov_q;
  logic [INDEX_WIDTH-1:0] onode_q;
  logic [VALUE_WIDTH-1:0] ow_q;

  logic [INDEX_WIDTH-1:0] last_w;
  logic [INDEX_WIDTH-1:0] inc1_w;
  logic [INDEX_WIDTH-1:0] inc2_w;
  logic [INDEX_WIDTH-1:0] next_col_w;
  logic                   next_fin_w;
  logic                   start_skip_w;
  logic                   start_fin_w;
  logic [INDEX_WIDTH-1:0] first_col_w;
  logic                   edge_w;

  // Last-column test happens before increment so N=2^W-1 never wraps.
  always_comb begin
    last_w     = n_q - INDEX_WIDTH'(1);
    inc1_w     = col_q + INDEX_WIDTH'(1);
    inc2_w     = col_q + INDEX_WIDTH'(2);
    next_fin_w = 1'b0;
    next_col_w = inc1_w;
    if (col_q == last_w) begin
      next_fin_w = 1'b1;
    end else if (SKIP_SELF && inc1_w == node_q) begin
      if (inc1_w == last_w) begin
        next_fin_w = 1'b1;
      end else begin
        next_col_w = inc2_w;
      end
    end
  end

  // A source of node 0 starts at column 1; with N==1 nothing is left.
  always_comb begin
    start_skip_w = SKIP_SELF && node == '0;
    start_fin_w  = number_of_nodes == '0
                || node >= number_of_nodes
                || (start_skip_w
                    && number_of_nodes == INDEX_WIDTH'(1));
    first_col_w  = start_skip_w ? INDEX_WIDTH'(1) : '0;
    edge_w       = bus.edge_value != VALUE_WIDTH'(NO_EDGE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      node_q  <= '0;
      n_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      qe_q    <= 1'b0;
      ov_q    <= 1'b0;
      onode_q <= '0;
      ow_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            node_q <= node;
            n_q    <= number_of_nodes;
            col_q  <= first_col_w;
            if (start_fin_w) begin
              done_q  <= 1'b1;
              state_q <= S_FIN;
            end else begin
              qe_q    <= 1'b1;
              state_q <= S_QUERY;
            end
          end
        end
        // ready may still be high from the previous column here.
        S_QUERY: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.ready) begin
            qe_q <= 1'b0;
            if (edge_w) begin
              onode_q <= col_q;
              ow_q    <= bus.edge_value;
              ov_q    <= 1'b1;
              state_q <= S_EMIT;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (next_fin_w) begin
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            col_q   <= next_col_w;
            qe_q    <= 1'b1;
            state_q <= S_QUERY;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign bus.query_enable = qe_q;
  assign bus.from_node    = node_q;
  assign bus.to_node      = col_q;
  assign bus.out_valid    = ov_q;
  assign bus.out_node     = onode_q;
  assign bus.out_weight   = ow_q;

endmodule

// File: tb/tb_neighbour_scanner.sv
// Bench for neighbour_scanner: EdgeCache model with random latency
// and stale ready, random-backpressure consumer, row-walk reference.
module tb_neighbour_scanner;

  logic       clk;
  logic       rst_n;
  logic [7:0] number_of_nodes;
  logic       start;
  logic [7:0] node;
  logic       busy;
  logic       done;

  neighbour_scanner_if #(.IW(8), .VW(16)) bus_if ();

  neighbour_scanner #(
    .INDEX_WIDTH(8),
    .VALUE_WIDTH(16),
    .SKIP_SELF  (1'b1)
  ) dut (
    .clock          (clk),
    .reset          (rst_n),
    .number_of_nodes(number_of_nodes),
    .start          (start),
    .node           (node),
    .busy           (busy),
    .done           (done),
    .bus            (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [15:0] mem [16][16];

  int          q_cnt;
  int          d_cnt;
  bit          first_seen;
  logic [7:0]  first_to;
  logic [7:0]  got_node [$];
  logic [15:0] got_w [$];
  logic [7:0]  exp_node [$];
  logic [15:0] exp_w [$];
  int          exp_q;
  int          exp_first;
  int          stall_left;

  bit          qe_prev;
  int          wait_left;
  bit          hold_pend;
  logic [7:0]  hold_node;
  logic [15:0] hold_w;
  bit          rdy;

  // EdgeCache model, consumer and observers, all on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend        = 1'b0;
      qe_prev          = 1'b0;
      bus_if.ready     = 1'b0;
      bus_if.out_ready = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bus_if.out_valid, 1);
        chk("hold_node", bus_if.out_node, hold_node);
        chk("hold_weight", bus_if.out_weight, hold_w);
      end
      if (bus_if.out_valid) begin
        if (stall_left > 0) begin
          rdy = 1'b0;
          stall_left--;
        end else begin
          rdy = ($urandom_range(0, 3) != 0);
        end
        if (rdy) begin
          got_node.push_back(bus_if.out_node);
          got_w.push_back(bus_if.out_weight);
        end
        hold_pend = !rdy;
        hold_node = bus_if.out_node;
        hold_w    = bus_if.out_weight;
      end else begin
        rdy       = 1'($urandom_range(0, 1));
        hold_pend = 1'b0;
      end
      bus_if.out_ready = rdy;

      if (bus_if.query_enable) begin
        chk("self_query",
            32'(bus_if.from_node != bus_if.to_node), 1);
        if (!qe_prev) begin
          q_cnt++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_to   = bus_if.to_node;
          end
          wait_left         = $urandom_range(1, 4);
          bus_if.ready      = 1'($urandom_range(0, 1));
          bus_if.edge_value = 16'($urandom);
        end else if (wait_left > 0) begin
          wait_left--;
          if (wait_left == 0) begin
            bus_if.ready      = 1'b1;
            bus_if.edge_value =
              mem[bus_if.from_node[3:0]][bus_if.to_node[3:0]];
          end else begin
            bus_if.ready      = 1'b0;
            bus_if.edge_value = 16'($urandom);
          end
        end
      end else begin
        bus_if.ready      = 1'($urandom_range(0, 1));
        bus_if.edge_value = 16'($urandom);
      end
      if (done) d_cnt++;
      qe_prev = bus_if.query_enable;
    end
  end

  // Reference: the row of s, every column except s, nonzero kept.
  task automatic build_model(input int s, input int n);
    logic [15:0] w;
    exp_node.delete();
    exp_w.delete();
    exp_q     = 0;
    exp_first = -1;
    if (n != 0 && s < n) begin
      for (int c = 0; c < n; c++) begin
        if (c != s) begin
          exp_q++;
          if (exp_first < 0) exp_first = c;
          w = mem[s % 16][c % 16];
          if (w != 16'd0) begin
            exp_node.push_back(8'(c));
            exp_w.push_back(w);
          end
        end
      end
    end
  endtask

  task automatic clear_obs();
    q_cnt      = 0;
    d_cnt      = 0;
    first_seen = 1'b0;
    got_node.delete();
    got_w.delete();
  endtask

  task automatic run_scan(input int s, input int n,
                          input int stall, input bit glitch);
    int i;
    int m;
    build_model(s, n);
    clear_obs();
    stall_left = stall;
    @(posedge clk); #1;
    node            = 8'(s);
    number_of_nodes = 8'(n);
    start           = 1'b1;
    @(posedge clk); #1;
    start           = 1'b0;
    node            = 8'($urandom);
    number_of_nodes = 8'($urandom);
    chk("busy_after_start", busy, 1);
    if (exp_q > 0) chk("qe_latency", bus_if.query_enable, 1);
    else chk("done_latency", done, 1);
    i = 0;
    while (d_cnt == 0 && i < 20000) begin
      @(posedge clk); #1;
      i++;
      if (glitch && i == 6) begin
        start = 1'b1;
        node  = 8'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (d_cnt == 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
    chk("busy_after_done", busy, 0);
    chk("done_count", d_cnt, 1);
    chk("query_count", q_cnt, exp_q);
    if (exp_q > 0) chk("first_col", first_to, exp_first);
    chk("emit_count", got_node.size(), exp_node.size());
    m = got_node.size() < exp_node.size()
      ? got_node.size() : exp_node.size();
    for (int k = 0; k < m; k++) begin
      chk("emit_node", got_node[k], exp_node[k]);
      chk("emit_weight", got_w[k], exp_w[k]);
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = 16'(256 * r + c + 1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mem[r][c] = ($urandom_range(0, 9) < 3)
                  ? 16'd0 : 16'($urandom_range(1, 65535));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_qe"}, bus_if.query_enable, 0);
    chk({tag, "_from"}, bus_if.from_node, 0);
    chk({tag, "_to"}, bus_if.to_node, 0);
    chk({tag, "_valid"}, bus_if.out_valid, 0);
    chk({tag, "_onode"}, bus_if.out_node, 0);
    chk({tag, "_oweight"}, bus_if.out_weight, 0);
  endtask

  task automatic reset_mid_scan();
    int i;
    build_model(3, 8);
    clear_obs();
    stall_left = 0;
    @(posedge clk); #1;
    node            = 8'd3;
    number_of_nodes = 8'd8;
    start           = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0;
    while (!(bus_if.query_enable && bus_if.to_node == 8'd4)
           && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    chk("reach_col4", bus_if.to_node, 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", d_cnt, 0);
    chk("midreset_idle", busy, 0);
  endtask

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    node            = '0;
    number_of_nodes = '0;
    stall_left      = 0;
    fill_pattern();
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    run_scan(3, 8, 0, 1'b0);

    mem[2][1] = 16'd0;
    mem[2][5] = 16'd0;
    mem[2][6] = 16'd0;
    run_scan(2, 8, 0, 1'b0);
    fill_pattern();

    run_scan(3, 8, 5, 1'b0);
    run_scan(0, 0, 0, 1'b0);
    run_scan(9, 8, 0, 1'b0);
    run_scan(0, 1, 0, 1'b0);
    run_scan(7, 8, 0, 1'b0);
    run_scan(0, 8, 0, 1'b0);

    reset_mid_scan();
    run_scan(3, 8, 0, 1'b0);

    run_scan(3, 8, 0, 1'b1);

    fill_random();
    run_scan(254, 255, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int n;
      int s;
      fill_random();
      n = $urandom_range(1, 14);
      s = $urandom_range(0, n);
      run_scan(s, n, $urandom_range(0, 3), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
